rv_instruction_aligner: RTL and testbench

- Sits directly upstream of the decompressing decoder.
- Consumes a stream of naturally aligned 32-bit fetch words and emits one whole instruction per handshake, with its PC and length.
- Compressed (16-bit) instructions may start on either halfword, and 32-bit instructions may straddle two fetch words; the aligner reassembles them.
- Redirects (branch/trap) flush the buffer and restart at a new PC.

---
 rtl/rv_fetch_pkg.sv | 15 +
 rtl/rv_instruction_aligner.sv | 136 +++++++++++++
 tb/tb_rv_instruction_aligner.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/rv_fetch_pkg.sv
// Shared fetch-path types and helpers for the instruction aligner and the decoder.
package rv_fetch_pkg;

    typedef logic [2:0] hw_cnt_t;

    function automatic int unsigned xlen_of(input bit rv64);
        return rv64 ? 32'd64 : 32'd32;
    endfunction

    // 48-bit and longer encodings report 2; the decoder flags them as illegal.
    function automatic hw_cnt_t inst_len(input logic [1:0] lo_bits);
        return (lo_bits != 2'b11) ? 3'd1 : 3'd2;
    endfunction

endpackage

// File: rtl/rv_instruction_aligner.sv
// Reassembles whole 16/32-bit RV instructions from aligned 32-bit fetch words.
// Macro RV_ALIGNER_C_EXT_EN enables compressed support; without it every instruction is 32-bit.
module rv_instruction_aligner
    import rv_fetch_pkg::*;
#(
    parameter bit           rv64     = 1'b1,
    parameter logic [63:0]  reset_pc = 64'h0,
    localparam int unsigned XLEN     = xlen_of(rv64)
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [31:0]     out_inst,
    output logic [XLEN-1:0] out_pc,
    output logic            out_is_compressed
);

    localparam logic [XLEN-1:0] PC_RESET = XLEN'(reset_pc) & ~XLEN'(1);
`ifdef RV_ALIGNER_C_EXT_EN
    localparam logic [XLEN-1:0] REDIR_MASK = ~XLEN'(1);
`else
    localparam logic [XLEN-1:0] REDIR_MASK = ~XLEN'(3);
`endif

    logic [3:0][15:0] buf_q, buf_d;
    hw_cnt_t          count_q, count_d, count_pop;
    logic [XLEN-1:0]  pc_q, pc_d;
    hw_cnt_t          len;
    logic             out_fire, in_fire;
    logic             drop_low;
    logic             push_two;
    logic [15:0]      push_lo, push_hi;

`ifdef RV_ALIGNER_C_EXT_EN
    logic drop_low_q, drop_low_d;
    assign drop_low = drop_low_q;
`else
    assign drop_low = 1'b0;
`endif

    always_comb begin
`ifdef RV_ALIGNER_C_EXT_EN
        len      = inst_len(buf_q[0][1:0]);
        out_valid = !redirect_valid &&
                    (((count_q >= 3'd1) && (len == 3'd1)) || (count_q >= 3'd2));
        out_fire = out_valid && out_ready;
        in_ready = (count_q <= 3'd2) || redirect_valid;
`else
        len      = 3'd2;
        out_valid = !redirect_valid && (count_q >= 3'd2);
        out_fire = out_valid && out_ready;
        // Two-halfword buffer: refill only when empty or draining this cycle.
        in_ready = (count_q == 3'd0) || out_fire || redirect_valid;
`endif
        in_fire           = in_valid && in_ready;
        out_is_compressed = out_valid && (len == 3'd1);
        out_inst          = '0;
        if (out_valid) begin
            out_inst = (len == 3'd1) ? {16'h0, buf_q[0]} : {buf_q[1], buf_q[0]};
        end
        out_pc = pc_q;
    end

    always_comb begin
        buf_d     = buf_q;
        count_d   = count_q;
        count_pop = count_q;
        pc_d      = pc_q;
`ifdef RV_ALIGNER_C_EXT_EN
        drop_low_d = drop_low_q;
`endif
        push_two = !drop_low;
        push_lo  = drop_low ? in_data[31:16] : in_data[15:0];
        push_hi  = in_data[31:16];

        if (redirect_valid) begin
            // Any word handshaken this cycle belongs to the old stream and is dropped.
            count_d = '0;
            pc_d    = redirect_pc & REDIR_MASK;
`ifdef RV_ALIGNER_C_EXT_EN
            drop_low_d = redirect_pc[1];
`endif
        end else begin
            if (out_fire) begin
                buf_d     = (len == 3'd1) ? {16'h0, buf_q[3:1]} : {32'h0, buf_q[3:2]};
                count_pop = count_q - len;
                pc_d      = pc_q + XLEN'({len, 1'b0});
            end
            count_d = count_pop;
            if (in_fire) begin
                // Append behind whatever survives this cycle's pop.
                for (int i = 0; i < 4; i++) begin
                    if (hw_cnt_t'(i) == count_pop) begin
                        buf_d[i] = push_lo;
                    end
                    if (push_two && (hw_cnt_t'(i) == count_pop + 3'd1)) begin
                        buf_d[i] = push_hi;
                    end
                end
                count_d = count_pop + (push_two ? 3'd2 : 3'd1);
`ifdef RV_ALIGNER_C_EXT_EN
                drop_low_d = 1'b0;
`endif
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            buf_q   <= '0;
            count_q <= '0;
            pc_q    <= PC_RESET;
        end else begin
            buf_q   <= buf_d;
            count_q <= count_d;
            pc_q    <= pc_d;
        end
    end

`ifdef RV_ALIGNER_C_EXT_EN
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            drop_low_q <= 1'b0;
        end else begin
            drop_low_q <= drop_low_d;
        end
    end
`endif

endmodule

// File: tb/tb_rv_instruction_aligner.sv
// Bench for rv_instruction_aligner: directed scenarios plus random traffic against a halfword-queue model.
module tb_rv_instruction_aligner;

`ifdef RV_ALIGNER_C_EXT_EN
    localparam bit C_EXT = 1'b1;
`else
    localparam bit C_EXT = 1'b0;
`endif
    localparam logic [63:0] RST_PC = 64'h0000_0000_8000_0000;

    logic        clock = 1'b0;
    logic        reset;
    logic        redirect_valid = 1'b0;
    logic [63:0] redirect_pc = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_data = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_inst;
    logic [63:0] out_pc;
    logic        out_is_compressed;

    rv_instruction_aligner #(.rv64(1'b1), .reset_pc(RST_PC)) dut (
        .clock(clock), .reset(reset),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst),
        .out_pc(out_pc), .out_is_compressed(out_is_compressed)
    );

    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s at cycle %0d: got %h expected %h", tag, cyc, got, exp);
        end
    endtask

    // Reference model: the buffered halfwords in program order.
    logic [15:0] m_q[$];
    logic [63:0] m_pc;
    bit          m_drop;

    // Instructions actually delivered by the DUT.
    logic [31:0] s_inst[$];
    logic [63:0] s_pc[$];
    int          s_cyc[$];

    function automatic int m_len();
        if (!C_EXT || m_q.size() == 0) return 2;
        return (m_q[0][1:0] == 2'b11) ? 2 : 1;
    endfunction

    task automatic model_reset();
        m_q.delete();
        m_pc   = RST_PC & ~64'h1;
        m_drop = 1'b0;
    endtask

    task automatic clear_seen();
        s_inst.delete();
        s_pc.delete();
        s_cyc.delete();
    endtask

    // One clock cycle: drive at the falling edge, check, advance the model.
    task automatic step(input logic rv, input logic [63:0] rpc, input logic iv,
                        input logic [31:0] d, input logic ordy, output logic took);
        int len;
        logic ev, eir, ofire, ifire;
        redirect_valid = rv;
        redirect_pc    = rpc;
        in_valid       = iv;
        in_data        = d;
        out_ready      = ordy;
        #1;
        len   = m_len();
        ev    = !rv && (m_q.size() >= len);
        ofire = ev && ordy;
        eir   = rv || (C_EXT ? (m_q.size() <= 2) : (m_q.size() == 0 || ofire));
        check_eq("out_valid", out_valid, ev);
        check_eq("in_ready", in_ready, eir);
        if (ev) begin
            check_eq("out_inst", out_inst, (len == 1) ? {16'h0, m_q[0]} : {m_q[1], m_q[0]});
            check_eq("out_pc", out_pc, m_pc);
            check_eq("out_is_compressed", out_is_compressed, len == 1);
        end else begin
            check_eq("idle_inst", out_inst, 0);
            check_eq("idle_compressed", out_is_compressed, 0);
        end
        if (out_valid && ordy) begin
            s_inst.push_back(out_inst);
            s_pc.push_back(out_pc);
            s_cyc.push_back(cyc);
        end
        ifire = iv && eir;
        took  = ifire && !rv;
        if (rv) begin
            m_q.delete();
            m_pc   = rpc & (C_EXT ? ~64'h1 : ~64'h3);
            m_drop = C_EXT && rpc[1];
        end else begin
            if (ofire) begin
                repeat (len) void'(m_q.pop_front());
                m_pc = m_pc + 64'(2 * len);
            end
            if (ifire) begin
                if (!m_drop) m_q.push_back(d[15:0]);
                m_q.push_back(d[31:16]);
                m_drop = 1'b0;
            end
        end
        cyc++;
        @(negedge clock);
    endtask

    task automatic idle(input int n);
        logic t;
        for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0, '0, 1'b1, t);
    endtask

    task automatic expect_seen(input string tag, input int n,
                               input logic [31:0] ei[4], input logic [63:0] ep[4]);
        check_eq({tag, "_count"}, s_inst.size(), n);
        for (int i = 0; i < n && i < s_inst.size(); i++) begin
            check_eq({tag, "_inst"}, s_inst[i], ei[i]);
            check_eq({tag, "_pc"}, s_pc[i], ep[i]);
        end
    endtask

    logic        took;
    logic [31:0] w[6];
    int          widx;
    logic [63:0] pc0;

    initial begin
        reset = 1'b1;
        #1;
        check_eq("rst_out_valid", out_valid, 0);
        check_eq("rst_in_ready", in_ready, 1);
        check_eq("rst_out_pc", out_pc, RST_PC);
        check_eq("rst_out_inst", out_inst, 0);
        check_eq("rst_compressed", out_is_compressed, 0);
        @(negedge clock);
        reset = 1'b0;
        model_reset();

        // Two back-to-back 32-bit instructions.
        clear_seen();
        step(1'b0, '0, 1'b1, 32'h0000_0013, 1'b1, took);
        step(1'b0, '0, 1'b1, 32'h0010_0093, 1'b1, took);
        idle(2);
        expect_seen("t1", 2, '{32'h13, 32'h0010_0093, 0, 0}, '{RST_PC, RST_PC + 4, 0, 0});
        if (s_cyc.size() == 2) check_eq("t1_spacing", s_cyc[1] - s_cyc[0], 1);

        // Two compressed instructions in one word.
        pc0 = RST_PC + 8;
        clear_seen();
        step(1'b0, '0, 1'b1, 32'h0001_4501, 1'b1, took);
        if (C_EXT) check_eq("t2_in_ready", in_ready, 1);
        idle(3);
`ifdef RV_ALIGNER_C_EXT_EN
        expect_seen("t2", 2, '{32'h4501, 32'h0001, 0, 0}, '{pc0, pc0 + 2, 0, 0});
        pc0 = pc0 + 4;
`else
        expect_seen("t2", 1, '{32'h0001_4501, 0, 0, 0}, '{pc0, 0, 0, 0});
        pc0 = pc0 + 4;
`endif

        // 32-bit instruction straddling two words.
        clear_seen();
        step(1'b0, '0, 1'b1, 32'h0013_4505, 1'b1, took);
        step(1'b0, '0, 1'b0, '0, 1'b1, took);
        step(1'b0, '0, 1'b0, '0, 1'b1, took);
        if (C_EXT) check_eq("t3_wait", out_valid, 0);
        step(1'b0, '0, 1'b1, 32'h0000_0000, 1'b1, took);
        idle(3);
`ifdef RV_ALIGNER_C_EXT_EN
        expect_seen("t3", 3, '{32'h4505, 32'h13, 32'h0, 0}, '{pc0, pc0 + 2, pc0 + 6, 0});
`else
        expect_seen("t3", 2, '{32'h0013_4505, 32'h0, 0, 0}, '{pc0, pc0 + 4, 0, 0});
`endif

        // Redirect to an odd halfword; the word offered in the redirect cycle is lost.
        clear_seen();
        step(1'b1, 64'h1002, 1'b1, 32'hDEAD_BEEF, 1'b1, took);
        step(1'b0, '0, 1'b1, 32'h4501_4505, 1'b1, took);
        idle(3);
`ifdef RV_ALIGNER_C_EXT_EN
        expect_seen("t4", 1, '{32'h4501, 0, 0, 0}, '{64'h1002, 0, 0, 0});
`else
        expect_seen("t4", 1, '{32'h4501_4505, 0, 0, 0}, '{64'h1000, 0, 0, 0});
`endif

        // Backpressure: stall the consumer while words keep coming.
        step(1'b1, 64'h2000, 1'b0, '0, 1'b0, took);
        clear_seen();
        for (int i = 0; i < 6; i++) w[i] = 32'h13 | (i << 20);
        widx = 0;
        for (int k = 0; k < 5; k++) begin
            step(1'b0, '0, 1'b1, w[widx], 1'b0, took);
            if (took) widx++;
            if (k == 1) check_eq("t5_full", in_ready, 0);
        end
        for (int k = 0; k < 40 && (widx < 6 || s_inst.size() < 6); k++) begin
            step(1'b0, '0, widx < 6, w[widx < 6 ? widx : 0], 1'b1, took);
            if (took) widx++;
        end
        check_eq("t5_count", s_inst.size(), 6);
        for (int i = 0; i < 6 && i < s_inst.size(); i++) begin
            check_eq("t5_inst", s_inst[i], w[i]);
            check_eq("t5_pc", s_pc[i], 64'h2000 + 64'(4 * i));
        end

        // PC wrap-around at the top of the address space.
        clear_seen();
        step(1'b1, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0, '0, 1'b1, took);
        step(1'b0, '0, 1'b1, 32'h13, 1'b1, took);
        step(1'b0, '0, 1'b1, 32'h13, 1'b1, took);
        idle(2);
        expect_seen("t7", 2, '{32'h13, 32'h13, 0, 0}, '{64'hFFFF_FFFF_FFFF_FFFC, 64'h0, 0, 0});

        // Asynchronous reset with a partly filled buffer.
        step(1'b1, 64'h3002, 1'b0, '0, 1'b0, took);
        step(1'b0, '0, 1'b1, 32'h4501_0000, 1'b0, took);
        step(1'b0, '0, 1'b1, 32'h0000_0013, 1'b0, took);
        #2;
        reset = 1'b1;
        #1;
        check_eq("t6_out_valid", out_valid, 0);
        check_eq("t6_in_ready", in_ready, 1);
        check_eq("t6_out_pc", out_pc, RST_PC);
        check_eq("t6_out_inst", out_inst, 0);
        @(negedge clock);
        reset = 1'b0;
        model_reset();
        clear_seen();
        step(1'b0, '0, 1'b1, 32'h13, 1'b1, took);
        idle(2);
        expect_seen("t6", 1, '{32'h13, 0, 0, 0}, '{RST_PC, 0, 0, 0});

        // Random traffic with occasional redirects.
        for (int k = 0; k < 3000; k++) begin
            logic        rv;
            logic [63:0] rpc;
            rv  = ($urandom_range(0, 99) < 3);
            rpc = ($urandom_range(0, 3) == 0) ? {32'hFFFF_FFFF, $urandom} : {32'h0, $urandom};
            step(rv, rpc, $urandom_range(0, 99) < 70, $urandom, $urandom_range(0, 99) < 70, took);
        end
        idle(4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
